// File: rtl/jump_control_sequencer.sv
`timescale 1ns/1ps
// Moore control sequencer driving CPU_Datapath strobes for fetch, jr, jal, br, nop and halt.
// Unsupported opcodes stop the machine and raise a sticky fault flag.
module jump_control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF_Out,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRread,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Zin,
  output logic        ZLowout,
  output logic        Yin,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        CON_FF_In,
  output logic [4:0]  ALUSelection,
  output logic        run,
  output logic        fault,
  output logic [3:0]  dbg_state_o
);

  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00001;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic       fault_q, fault_d;
  logic [4:0] opcode;
  logic       unused_ir_bits;

  assign opcode         = IR[31:27];
  assign unused_ir_bits = ^IR[26:0];
  assign fault          = fault_q;
  assign dbg_state_o    = state_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fault_d      = fault_q;
    PCout        = 1'b0;
    PCin         = 1'b0;
    IncPC        = 1'b0;
    MARin        = 1'b0;
    MDRread      = 1'b0;
    MDRin        = 1'b0;
    MDRout       = 1'b0;
    IRin         = 1'b0;
    Zin          = 1'b0;
    ZLowout      = 1'b0;
    Yin          = 1'b0;
    Cout         = 1'b0;
    Gra          = 1'b0;
    Grb          = 1'b0;
    Grc          = 1'b0;
    Rin          = 1'b0;
    Rout         = 1'b0;
    BAout        = 1'b0;
    CON_FF_In    = 1'b0;
    ALUSelection = 5'd0;
    run          = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0: begin
        run     = 1'b1;
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        // A stop request abandons the fetch before MDRread ever fires.
        state_d = stop ? S_HALT : S_T1;
      end
      S_T1: begin
        run     = 1'b1;
        ZLowout = 1'b1;
        PCin    = 1'b1;
        MDRread = 1'b1;
        MDRin   = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        run     = 1'b1;
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        run = 1'b1;
        case (opcode)
          OP_JR: begin
            Gra     = 1'b1;
            Rout    = 1'b1;
            PCin    = 1'b1;
            state_d = S_T0;
          end
          OP_JAL: begin
            PCout   = 1'b1;
            Grb     = 1'b1;
            Rin     = 1'b1;
            state_d = S_T4;
          end
          OP_BR: begin
            Gra       = 1'b1;
            Rout      = 1'b1;
            CON_FF_In = 1'b1;
            state_d   = S_T4;
          end
          OP_NOP:  state_d = S_T0;
          OP_HALT: state_d = S_HALT;
          default: begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_T4: begin
        run = 1'b1;
        case (opcode)
          OP_JAL: begin
            Gra     = 1'b1;
            Rout    = 1'b1;
            PCin    = 1'b1;
            state_d = S_T0;
          end
          OP_BR: begin
            PCout   = 1'b1;
            Yin     = 1'b1;
            state_d = S_T5;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        run     = 1'b1;
        Cout    = 1'b1;
        Zin     = 1'b1;
        state_d = S_T6;
      end
      S_T6: begin
        run     = 1'b1;
        ZLowout = 1'b1;
        PCin    = CON_FF_Out;
        state_d = S_T0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    ALUSelection = Zin ? ALU_ADD : 5'd0;
  end

endmodule

// File: tb/tb_jump_control_sequencer.sv
`timescale 1ns/1ps
// Randomized bench for jump_control_sequencer: per-cycle strobe vectors are
// compared against an instruction-level model of the control sequences.
module tb_jump_control_sequencer;

  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [25:0] M_PCOUT   = 26'd1 << 0;
  localparam logic [25:0] M_PCIN    = 26'd1 << 1;
  localparam logic [25:0] M_INCPC   = 26'd1 << 2;
  localparam logic [25:0] M_MARIN   = 26'd1 << 3;
  localparam logic [25:0] M_MDRREAD = 26'd1 << 4;
  localparam logic [25:0] M_MDRIN   = 26'd1 << 5;
  localparam logic [25:0] M_MDROUT  = 26'd1 << 6;
  localparam logic [25:0] M_IRIN    = 26'd1 << 7;
  localparam logic [25:0] M_ZIN     = 26'd1 << 8;
  localparam logic [25:0] M_ZLOWOUT = 26'd1 << 9;
  localparam logic [25:0] M_YIN     = 26'd1 << 10;
  localparam logic [25:0] M_COUT    = 26'd1 << 11;
  localparam logic [25:0] M_GRA     = 26'd1 << 12;
  localparam logic [25:0] M_GRB     = 26'd1 << 13;
  localparam logic [25:0] M_RIN     = 26'd1 << 15;
  localparam logic [25:0] M_ROUT    = 26'd1 << 16;
  localparam logic [25:0] M_CONFFIN = 26'd1 << 18;
  localparam logic [25:0] M_ADDSEL  = 26'd1 << 19;
  localparam logic [25:0] M_RUN     = 26'd1 << 24;
  localparam logic [25:0] M_FAULT   = 26'd1 << 25;
  localparam logic [25:0] M_DRIVERS = M_PCOUT | M_ZLOWOUT | M_MDROUT | M_ROUT | M_COUT;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] IR = 32'd0;
  logic        CON_FF_Out = 1'b0;
  logic        stop = 1'b0;
  logic        PCout, PCin, IncPC, MARin, MDRread, MDRin, MDRout, IRin;
  logic        Zin, ZLowout, Yin, Cout, Gra, Grb, Grc, Rin, Rout, BAout, CON_FF_In;
  logic [4:0]  ALUSelection;
  logic        run, fault;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [25:0] got_q[$];

  jump_control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_FF_Out(CON_FF_Out), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRread(MDRread),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Zin(Zin), .ZLowout(ZLowout),
    .Yin(Yin), .Cout(Cout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .CON_FF_In(CON_FF_In), .ALUSelection(ALUSelection),
    .run(run), .fault(fault), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] sample_outs();
    return {fault, run, ALUSelection, CON_FF_In, BAout, Rout, Rin, Grc, Grb, Gra,
            Cout, Yin, ZLowout, Zin, IRin, MDRout, MDRin, MDRread, MARin, IncPC, PCin, PCout};
  endfunction

  function automatic bit op_supported(input logic [4:0] op);
    return (op == OP_JR) || (op == OP_JAL) || (op == OP_BR) || (op == OP_NOP);
  endfunction

  function automatic int instr_len(input logic [4:0] op);
    case (op)
      OP_JAL:  return 5;
      OP_BR:   return 7;
      default: return 4;
    endcase
  endfunction

  // Expected outputs in cycle i of an instruction (i == 0 is its T0); cycles at or
  // past the instruction length are the next fetch or the halted machine.
  function automatic logic [25:0] exp_vec(input logic [4:0] op, input logic con, input int i);
    logic [25:0] v;
    int          c;
    v = '0;
    c = i;
    if (i >= instr_len(op)) begin
      if (op != OP_NOP && !op_supported(op) || op == OP_HALT) begin
        if (op != OP_HALT) v = M_FAULT;
        return v;
      end
      c = 0;
    end
    v = M_RUN;
    case (c)
      0: v |= M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
      1: v |= M_ZLOWOUT | M_PCIN | M_MDRREAD | M_MDRIN;
      2: v |= M_MDROUT | M_IRIN;
      3: begin
        if (op == OP_JR)  v |= M_GRA | M_ROUT | M_PCIN;
        if (op == OP_JAL) v |= M_PCOUT | M_GRB | M_RIN;
        if (op == OP_BR)  v |= M_GRA | M_ROUT | M_CONFFIN;
      end
      4: begin
        if (op == OP_JAL) v |= M_GRA | M_ROUT | M_PCIN;
        if (op == OP_BR)  v |= M_PCOUT | M_YIN;
      end
      5: v |= M_COUT | M_ZIN;
      6: v |= M_ZLOWOUT | (con ? M_PCIN : 26'd0);
      default: v = v;
    endcase
    if ((v & M_ZIN) != 0) v |= M_ADDSEL;
    return v;
  endfunction

  // Starts at a falling edge inside T0; samples nsamp cycles, scrambling every
  // input that the sequencer is not supposed to look at in that cycle.
  task automatic run_instr(input logic [31:0] ir, input logic con, input logic stop_t0,
                           input int len, input int nsamp);
    got_q.delete();
    for (int i = 0; i < nsamp; i++) begin
      got_q.push_back(sample_outs());
      if (i == 0)       stop = stop_t0;
      else if (i < len) stop = 1'($urandom_range(0, 1));
      else              stop = 1'b0;
      if (i < 2 || i > len) IR = $urandom;
      else if (i == 2)      IR = ir;
      if (i == 5)      CON_FF_Out = con;
      else if (i != 6) CON_FF_Out = 1'($urandom_range(0, 1));
      if (i != nsamp - 1) @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clr  = 1'b0;
    stop = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [25:0] obs;
    IR = $urandom;
    #1 clr = 1'b0;
    @(negedge clk);
    obs = sample_outs();
    n_checks++;
    if (obs !== 26'd0) $display("FAIL reset_outs got=%h exp=%h", obs, 26'd0);
    else n_pass++;
    clr = 1'b1;
    #1 obs = sample_outs();
    n_checks++;
    if (obs !== 26'd0) $display("FAIL idle_outs got=%h exp=%h", obs, 26'd0);
    else n_pass++;
    @(negedge clk);
    obs = sample_outs();
    n_checks++;
    if (obs !== exp_vec(OP_NOP, 1'b0, 0)) $display("FAIL first_t0 got=%h exp=%h", obs, exp_vec(OP_NOP, 1'b0, 0));
    else n_pass++;
  endtask

  task automatic test_jr();
    logic con;
    con = 1'($urandom_range(0, 1));
    run_instr(32'hA1000000, con, 1'b0, 4, 5);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_vec(OP_JR, con, i)) $display("FAIL jr cyc%0d got=%h exp=%h", i, got_q[i], exp_vec(OP_JR, con, i));
      else n_pass++;
    end
  endtask

  task automatic test_jal();
    logic con;
    con = 1'($urandom_range(0, 1));
    run_instr(32'hA8000000, con, 1'b0, 5, 6);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_vec(OP_JAL, con, i)) $display("FAIL jal cyc%0d got=%h exp=%h", i, got_q[i], exp_vec(OP_JAL, con, i));
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    for (int r = 0; r < 2; r++) begin
      logic con;
      con = (r == 0);
      run_instr(32'h98000000, con, 1'b0, 7, 8);
      foreach (got_q[i]) begin
        n_checks++;
        if (got_q[i] !== exp_vec(OP_BR, con, i)) $display("FAIL br con=%0d cyc%0d got=%h exp=%h", con, i, got_q[i], exp_vec(OP_BR, con, i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_nop();
    for (int r = 0; r < 2; r++) begin
      run_instr(32'hD0000000, 1'b0, 1'b0, 4, 5);
      foreach (got_q[i]) begin
        n_checks++;
        if (got_q[i] !== exp_vec(OP_NOP, 1'b0, i)) $display("FAIL nop cyc%0d got=%h exp=%h", i, got_q[i], exp_vec(OP_NOP, 1'b0, i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] ops[4];
    ops = '{OP_JR, OP_JAL, OP_BR, OP_NOP};
    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      logic       con;
      int         len;
      op  = ops[$urandom_range(0, 3)];
      con = 1'($urandom_range(0, 1));
      len = instr_len(op);
      run_instr({op, 27'($urandom)}, con, 1'b0, len, len + 1);
      foreach (got_q[i]) begin
        n_checks++;
        if (got_q[i] !== exp_vec(op, con, i) || $countones(got_q[i] & M_DRIVERS) > 1)
          $display("FAIL rand n%0d op=%b cyc%0d got=%h exp=%h", n, op, i, got_q[i], exp_vec(op, con, i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [25:0] obs;
    IR = 32'hA8000000;
    @(negedge clk);
    obs = sample_outs();
    n_checks++;
    if (obs !== exp_vec(OP_JAL, 1'b0, 1)) $display("FAIL mid_t1 got=%h exp=%h", obs, exp_vec(OP_JAL, 1'b0, 1));
    else n_pass++;
    #2 clr = 1'b0;
    #1 obs = sample_outs();
    n_checks++;
    if (obs !== 26'd0) $display("FAIL mid_reset_drop got=%h exp=%h", obs, 26'd0);
    else n_pass++;
    repeat (2) begin
      @(posedge clk);
      #1 obs = sample_outs();
      n_checks++;
      if (obs !== 26'd0) $display("FAIL mid_reset_hold got=%h exp=%h", obs, 26'd0);
      else n_pass++;
    end
    @(negedge clk);
    clr = 1'b1;
    #1 obs = sample_outs();
    n_checks++;
    if (obs !== 26'd0) $display("FAIL mid_idle got=%h exp=%h", obs, 26'd0);
    else n_pass++;
    @(negedge clk);
    obs = sample_outs();
    n_checks++;
    if (obs !== exp_vec(OP_NOP, 1'b0, 0)) $display("FAIL mid_t0 got=%h exp=%h", obs, exp_vec(OP_NOP, 1'b0, 0));
    else n_pass++;
  endtask

  task automatic test_halt();
    run_instr(32'hD8000000, 1'b0, 1'b0, 4, 16);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_vec(OP_HALT, 1'b0, i)) $display("FAIL halt cyc%0d got=%h exp=%h", i, got_q[i], exp_vec(OP_HALT, 1'b0, i));
      else n_pass++;
    end
    apply_reset();
  endtask

  task automatic test_stop();
    logic [25:0] e;
    run_instr({OP_JR, 27'($urandom)}, 1'b0, 1'b1, 1, 12);
    foreach (got_q[i]) begin
      e = (i == 0) ? exp_vec(OP_NOP, 1'b0, 0) : 26'd0;
      n_checks++;
      if (got_q[i] !== e) $display("FAIL stop cyc%0d got=%h exp=%h", i, got_q[i], e);
      else n_pass++;
    end
    apply_reset();
  endtask

  task automatic test_fault();
    logic [25:0] obs;
    run_instr(32'hF8000000, 1'b0, 1'b0, 4, 14);
    foreach (got_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_vec(5'b11111, 1'b0, i)) $display("FAIL fault cyc%0d got=%h exp=%h", i, got_q[i], exp_vec(5'b11111, 1'b0, i));
      else n_pass++;
    end
    @(negedge clk);
    clr = 1'b0;
    #1 obs = sample_outs();
    n_checks++;
    if (obs !== 26'd0) $display("FAIL fault_clear got=%h exp=%h", obs, 26'd0);
    else n_pass++;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    obs = sample_outs();
    n_checks++;
    if (obs !== exp_vec(OP_NOP, 1'b0, 0)) $display("FAIL fault_restart got=%h exp=%h", obs, exp_vec(OP_NOP, 1'b0, 0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_jr();
    test_jal();
    test_branch();
    test_nop();
    test_random();
    test_reset_mid();
    test_halt();
    test_stop();
    test_fault();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d of %0d checks", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/jump_control_sequencer.md
# jump_control_sequencer

Moore-style control sequencer that sits directly upstream of `CPU_Datapath` and generates its per-cycle control strobes. It replaces hand-sequenced bench stimulus for the instruction-fetch cycle and the control-transfer instructions (`jr`, `jal`, conditional branch), plus `nop` and `halt`. Any other opcode halts the machine with a fault flag.

## Interface
- `OP_BR`, 5'b10011: conditional branch opcode (IR[31:27]).
- `OP_JR`, 5'b10100: jump-register opcode.
- `OP_JAL`, 5'b10101: jump-and-link opcode.
- `OP_NOP`, 5'b11010: no-operation opcode.
- `OP_HALT`, 5'b11011: halt opcode.
- `ALU_ADD`, 5'b00001: ALUSelection code for add.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `IR`  in  32  instruction register contents from the datapath.
- `CON_FF_Out`  in  1  branch-condition flip-flop from the datapath.
- `stop`  in  1  external halt request.
- `PCout`, `PCin`, `IncPC`, `MARin`, `MDRread`, `MDRin`, `MDRout`, `IRin`  out  1 each  datapath strobes.
- `Zin`, `ZLowout`, `Yin`, `Cout`  out  1 each  ALU-path strobes.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`, `CON_FF_In`  out  1 each  register-select strobes and condition-logic strobes.
- `ALUSelection`  out  5  operation select; equals `ALU_ADD` whenever `Zin`=1, otherwise 0.
- `run`  out  1  high while the machine is sequencing instructions.
- `fault`  out  1  sticky flag set when an unsupported opcode is decoded.

## Operation
- States: `IDLE`, `T0`–`T6`, `HALT`. One state per clock.
- Outputs are a combinational decode of the state register and IR[31:27]. Any strobe not listed for a state is 0.
- **`IDLE`**:
  - All strobes 0; `run`=0.
  - Next state: `T0`.
- **`T0`**:
  - Strobes: `PCout`, `MARin`, `IncPC`, `Zin`.
  - If `stop`=1 at this edge, next state is `HALT` and no fetch commits. Otherwise next state is `T1`.
- **`T1`**: `ZLowout`, `PCin`, `MDRread`, `MDRin`. Next state: `T2`.
- **`T2`**: `MDRout`, `IRin`. Next state: always `T3`. IR becomes valid at the end of this cycle.
- **`T3`**: decode IR[31:27].
  - `jr`: `Gra`, `Rout`, `PCin`. Next state: `T0`.
  - `jal`: `PCout`, `Grb`, `Rin` (return address written to the Rb field). Next state: `T4`.
  - `br`: `Gra`, `Rout`, `CON_FF_In`. Next state: `T4`.
  - `nop`: no strobes. Next state: `T0`.
  - `halt`: no strobes. Next state: `HALT`.
  - Any other opcode: no strobes; `fault` is set. Next state: `HALT`.
- **`T4`**:
  - `jal`: `Gra`, `Rout`, `PCin`. Next state: `T0`.
  - `br`: `PCout`, `Yin`. Next state: `T5`.
- **`T5`** (`br` only): `Cout`, `Zin`, `ALUSelection`=`ALU_ADD`. Next state: `T6`.
- **`T6`** (`br` only):
  - Strobes: `ZLowout`; `PCin` = `CON_FF_Out`.
  - Next state: `T0`.
- **`HALT`**:
  - All strobes 0; `run`=0.
  - Only `clr` exits this state.
- `run`=1 in states `T0`–`T6`.
- `fault` is cleared only by `clr`.

## Timing
- Reset (`clr`=0) forces `IDLE` immediately, independent of the clock. While in reset, every strobe, `ALUSelection`, `run` and `fault` are 0.
- After `clr` deasserts, `IDLE` lasts 1 cycle, then `T0`.
- Instruction lengths in cycles, fetch included:
  - `jr`: 4.
  - `nop`: 4.
  - `jal`: 5.
  - `br`: 7.
  - `halt` and unsupported opcodes: 4, then `HALT`.
- `CON_FF_Out` is sampled only during `T6`. The flip-flop is loaded at the end of `T3`, so it is stable by then.
- IR is consulted only in `T3`–`T6`. IR changes outside those states have no effect.
- `stop` is sampled only in `T0`. A `stop` pulse that falls entirely within `T1`–`T6` is ignored.
- If `clr` asserts mid-instruction, all strobes drop in the same cycle. No partial write follows; in particular, no `PCin` is issued after the reset.
- At most one of `PCout`, `ZLowout`, `MDRout`, `Rout`, `Cout` is high in any state (single bus driver).

## Test plan
- **Reset**: drive `clr`=0 mid-`T1`. Required: all outputs 0 within the same cycle. After release, exactly 1 `IDLE` cycle, then `T0` with `PCout`=`MARin`=`IncPC`=`Zin`=1 and `ALUSelection`=5'b00001.
- **`jr`**: IR=32'hA1000000. Required: T0/T1/T2 strobes as specified; `T3` shows `Gra`=`Rout`=`PCin`=1; `T0` is entered 4 cycles after the previous `T0`.
- **`jal`**: IR=32'hA8000000. Required: `T3` shows `PCout`=`Grb`=`Rin`=1; `T4` shows `Gra`=`Rout`=`PCin`=1; 5-cycle period.
- **Branch**: IR=32'h98000000.
  - Run once with `CON_FF_Out`=1: `T5` shows `Cout`=`Zin`=1 with `ALUSelection`=00001; `T6` shows `PCin`=1.
  - Run again with `CON_FF_Out`=0: `T6` shows `PCin`=0.
  - Both runs take 7 cycles.
- **Halt paths**:
  - IR=32'hD8000000: `run` falls after `T3`; the machine stays in `HALT` for more than 10 cycles with all strobes 0.
  - `stop`=1 during `T0`: `HALT` is entered without `MDRread` ever asserting.
- **Nop and fault**:
  - IR=32'hD0000000: 4-cycle loop with no `T3` strobes.
  - IR=32'hF8000000: `fault`=1 and the machine halts; `fault` stays 1 until `clr`=0.
